// File: rtl/io_input_pkg.sv
// Shared constants and types for the board input MMIO block (switches + buttons).
package io_input_pkg;

    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned NUM_SW  = 32;

    localparam logic [7:0] SW_OFF         = 8'h00;
    localparam logic [7:0] BTN_OFF        = 8'h10;
    localparam logic [7:0] BTN_EDGE_OFF   = 8'h14;
    localparam logic [7:0] BTN_IRQ_EN_OFF = 8'h18;
    localparam logic [7:0] EVT_CNT_OFF    = 8'h1C;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    function automatic logic [2:0] btn_popcount(input btn_vec_t v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/io_input_ctrl_if.sv
// LSU-side MMIO port of the input block: address/strobe/data in, hit/read data out.
interface io_input_ctrl_if;

    logic [31:0] i_lsu_addr;
    logic        i_lsu_we;
    logic [31:0] i_lsu_wdata;
    logic        o_hit;
    logic [31:0] o_rdata;

    modport master (
        output i_lsu_addr, i_lsu_we, i_lsu_wdata,
        input  o_hit, o_rdata
    );

    modport slave (
        input  i_lsu_addr, i_lsu_we, i_lsu_wdata,
        output o_hit, o_rdata
    );

endinterface

// File: rtl/io_debounce.sv
// 2-flop synchroniser followed by a tick-sampled three-sample agreement filter.
module io_debounce #(
    parameter int unsigned W       = 1,
    parameter logic        RST_LVL = 1'b0,
    parameter logic        INVERT  = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_db,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_sync1, r_sync2;
    logic [W-1:0] r_s0, r_s1, r_db;
    logic [W-1:0] w_sync_out, w_agree, w_db_nxt;

    assign w_sync_out = r_sync2 ^ {W{INVERT}};

    // The oldest sample of the window is r_s1 before the shift, so the
    // three-way agreement uses s1, s0 and the incoming sample directly.
    always_comb begin
        w_agree  = '0;
        w_db_nxt = r_db;
        if (i_tick) begin
            w_agree  = ~(r_s1 ^ r_s0) & ~(r_s0 ^ w_sync_out);
            w_db_nxt = (r_db & ~w_agree) | (r_s0 & w_agree);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= {W{RST_LVL}};
            r_sync2 <= {W{RST_LVL}};
            r_s0    <= '0;
            r_s1    <= '0;
            r_db    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_s1 <= r_s0;
                r_s0 <= w_sync_out;
            end
            r_db <= w_db_nxt;
        end
    end

    assign o_db   = r_db;
    assign o_rise = w_db_nxt & ~r_db;

endmodule

// File: rtl/io_input_ctrl.sv
// MMIO responder for switches and push-buttons: debounced reads, sticky W1C
// press flags, press-event counter and a registered button interrupt.
module io_input_ctrl
    import io_input_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_7800,
    parameter int unsigned DB_TICK        = 50_000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_SW-1:0] i_io_sw,
    input  btn_vec_t          i_io_btn,
    io_input_ctrl_if.slave    lsu,
    output logic              o_btn_irq
);

    localparam int unsigned PW = $clog2(DB_TICK);

    logic [PW-1:0]     r_presc;
    logic              w_tick;
    logic [NUM_SW-1:0] w_sw_db, w_sw_rise_unused;
    btn_vec_t          w_btn_db, w_btn_rise;
    btn_vec_t          r_edge, r_en;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_irq;
    logic              w_hit, w_wr_edge, w_wr_en;
    logic [7:0]        w_off;
    logic [31:0]       w_rdata;
    btn_vec_t          w_clr;
    logic              w_wdata_unused;

    assign w_tick = (r_presc == PW'(DB_TICK - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    io_debounce #(.W(NUM_SW), .RST_LVL(1'b0), .INVERT(1'b0)) u_sw_db (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (w_tick),
        .i_raw  (i_io_sw),
        .o_db   (w_sw_db),
        .o_rise (w_sw_rise_unused)
    );

    io_debounce #(.W(NUM_BTN), .RST_LVL(BTN_ACTIVE_LOW), .INVERT(BTN_ACTIVE_LOW)) u_btn_db (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tick (w_tick),
        .i_raw  (i_io_btn),
        .o_db   (w_btn_db),
        .o_rise (w_btn_rise)
    );

    assign w_off          = lsu.i_lsu_addr[7:0];
    assign w_hit          = (lsu.i_lsu_addr[31:8] == BASE_ADDR[31:8]);
    assign w_wr_edge      = lsu.i_lsu_we && w_hit && (w_off == BTN_EDGE_OFF);
    assign w_wr_en        = lsu.i_lsu_we && w_hit && (w_off == BTN_IRQ_EN_OFF);
    assign w_clr          = w_wr_edge ? lsu.i_lsu_wdata[NUM_BTN-1:0] : '0;
    assign w_wdata_unused = ^lsu.i_lsu_wdata[31:NUM_BTN];

    // Set is OR'd in after the clear so a coincident press is never lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_edge <= '0;
            r_en   <= '0;
            r_cnt  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_btn_rise;
            if (w_wr_en) begin
                r_en <= lsu.i_lsu_wdata[NUM_BTN-1:0];
            end
            r_cnt <= r_cnt + CNT_W'(btn_popcount(w_btn_rise));
            r_irq <= |(r_edge & r_en);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                SW_OFF:         w_rdata = w_sw_db;
                BTN_OFF:        w_rdata = 32'(w_btn_db);
                BTN_EDGE_OFF:   w_rdata = 32'(r_edge);
                BTN_IRQ_EN_OFF: w_rdata = 32'(r_en);
                EVT_CNT_OFF:    w_rdata = 32'(r_cnt);
                default:        w_rdata = '0;
            endcase
        end
    end

    assign lsu.o_hit   = w_hit;
    assign lsu.o_rdata = w_rdata;
    assign o_btn_irq   = r_irq;

endmodule
